acq_rr_arbiter: RTL and testbench
=================================

// Module: acq_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one acquisition resource (shared sample bus / ADC
//   port) among N_REQ requesters. Grants one requester at a time, holds the grant
//   while its request stays high, and rotates priority after each grant.
//   Sits between the acquisition front-ends and the shared resource; grant_id
//   drives the resource's input select.
// PARAMETERS
//   N_REQ     4    number of requesters (2..8)
//   MAX_HOLD  16   max consecutive grant cycles, used only with ARB_TIMEOUT_EN (1..255)
// PORTS
//   clk       in   1              single clock, rising edge
//   rst       in   1              asynchronous, active-high reset
//   req       in   N_REQ          request vector; bit i high = requester i wants resource
//   grant     out  N_REQ          one-hot grant vector, registered; all-zero when idle
//   grant_id  out  $clog2(N_REQ)  index of granted requester; valid only when busy=1
//   busy      out  1              registered; = |grant
//   any_req   out  1              combinational; = |req
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, grant=0, grant_id=0, busy=0, ptr=N_REQ-1,
//     hold_cnt=0. Effective immediately, including mid-grant; no grant pulse on release.
//   - FSM states: IDLE, GRANT.
//     IDLE: if any req bit high at edge t -> pick winner, go GRANT; grant/busy high
//       from t+1 (1-cycle latency). If req=0, stay IDLE.
//     GRANT: if req[grant_id]=0 at edge t -> grant=0, busy=0 at t+1, go IDLE.
//       Mandatory 1-cycle bubble between consecutive grants, even to another requester.
//   - Winner selection: search starts at (ptr+1) mod N_REQ and wraps upward; first set
//     req bit wins. On grant, ptr <= winner index. After reset, req[0] has top priority.
//   - Wrap-around: with ptr=N_REQ-1 the search order is 0,1,..,N_REQ-1.
//   - Simultaneous requests: exactly one grant; the others wait, never dropped.
//   - Requests arriving or toggling for non-granted bits during GRANT: ignored until IDLE.
//   - grant is always one-hot or zero; grant_id stable for the whole grant.
//   - hold_cnt counts grant cycles; cleared on entry to GRANT; saturates at MAX_HOLD.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - when hold_cnt reaches MAX_HOLD with req[grant_id] still high, grant is revoked
//       at the next edge (grant high exactly MAX_HOLD cycles), state -> IDLE.
//     - the revoked requester is masked for that IDLE selection cycle only; if it is
//       the only requester it is re-granted one cycle later.
//   ARB_TIMEOUT_EN undefined:
//     - no timeout; grant held indefinitely while req[grant_id]=1; hold_cnt logic
//       removed; MAX_HOLD unused.
// TESTING
//   1 Reset: rst=1 with req=4'b1111 -> grant=0, busy=0; release rst -> grant=4'b0001
//     one cycle after the first edge, grant_id=0.
//   2 Rotation: req=4'b1111 held, each requester drops req 3 cycles after its grant ->
//     grant order 0,1,2,3,0 with one idle cycle between grants.
//   3 Wrap: ptr=2 (last grant to 2), req=4'b0011 -> grant_id=0 next, then 1.
//   4 Hold: only req[2]=1 for 40 cycles -> without ARB_TIMEOUT_EN grant=4'b0100 for
//     40 cycles; with it, 16 cycles high, 1 low, 16 high, ... (MAX_HOLD=16).
//   5 Timeout fairness (ARB_TIMEOUT_EN): req[1] held, req[3] raised during grant 1 ->
//     after 16 cycles, 1-cycle bubble, then grant=4'b1000.
//   6 Async reset mid-grant: assert rst between edges while grant=4'b0010 -> grant=0
//     immediately; after release with req=4'b0010 -> regrant to 1 with ptr restarted.

Source files
------------

// File: rtl/acq_rr_arbiter_if.sv
// Request/grant bundle between the acquisition front-ends and the shared-resource arbiter.
// master: requester side; slave: arbiter side.
interface acq_rr_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             busy;
   logic             any_req;

   modport master (
      output req,
      input  grant,
      input  grant_id,
      input  busy,
      input  any_req
   );

   modport slave (
      input  req,
      output grant,
      output grant_id,
      output busy,
      output any_req
   );
endinterface

// File: rtl/acq_rr_arbiter.sv
// Round-robin arbiter for one shared acquisition resource (sample bus / ADC port).
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; selects next winner from req, starting after ptr
//   GRANT | one requester owns the resource while its req stays high
module acq_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   acq_rr_arbiter_if.slave  bus
);
   localparam int ID_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
      $error("acq_rr_arbiter: N_REQ must be 2..8 and MAX_HOLD 1..255");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [N_REQ-1:0] grant_r;
   logic [N_REQ-1:0] grant_next;
   logic             busy_r;
   logic [ID_W-1:0]  id_r;
   logic [ID_W-1:0]  id_next;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  ptr_next;

   logic [N_REQ-1:0] cand;
   logic [ID_W-1:0]  winner;
   logic             found;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = 8;

   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_next;
   logic              mask_vld;
   logic              mask_vld_next;
   logic [ID_W-1:0]   mask_id;
   logic [ID_W-1:0]   mask_id_next;
   logic [N_REQ-1:0]  masked_req;
   logic              timeout;

   // A revoked requester sits out one selection only if someone else is waiting.
   assign masked_req = mask_vld ? (bus.req & ~(N_REQ'(1) << mask_id)) : bus.req;
   assign cand       = (|masked_req) ? masked_req : bus.req;
   // hold_cnt is 0 in the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle.
   assign timeout    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
   assign cand = bus.req;
`endif

   always_comb begin
      logic [ID_W-1:0] idx;
      idx    = '0;
      winner = '0;
      found  = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ID_W'((int'(ptr) + i) % N_REQ);
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant_r;
      id_next    = id_r;
      ptr_next   = ptr;
`ifdef ARB_TIMEOUT_EN
      hold_next     = hold_cnt;
      mask_vld_next = mask_vld;
      mask_id_next  = mask_id;
`endif
      case (state)
         IDLE: begin
`ifdef ARB_TIMEOUT_EN
            mask_vld_next = 1'b0;
`endif
            if (found) begin
               state_next = GRANT;
               grant_next = N_REQ'(1) << winner;
               id_next    = winner;
               ptr_next   = winner;
`ifdef ARB_TIMEOUT_EN
               hold_next  = '0;
`endif
            end
         end
         GRANT: begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
               hold_next = hold_cnt + 1'b1;
            end
`endif
            if (!bus.req[id_r]) begin
               state_next = IDLE;
               grant_next = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (timeout) begin
               state_next    = IDLE;
               grant_next    = '0;
               mask_vld_next = 1'b1;
               mask_id_next  = id_r;
            end
`endif
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant_r <= '0;
         busy_r  <= 1'b0;
         id_r    <= '0;
         ptr     <= ID_W'(N_REQ - 1);
      end else begin
         state   <= state_next;
         grant_r <= grant_next;
         busy_r  <= |grant_next;
         id_r    <= id_next;
         ptr     <= ptr_next;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         mask_vld <= 1'b0;
         mask_id  <= '0;
      end else begin
         hold_cnt <= hold_next;
         mask_vld <= mask_vld_next;
         mask_id  <= mask_id_next;
      end
   end
`endif

   assign bus.grant    = grant_r;
   assign bus.grant_id = id_r;
   assign bus.busy     = busy_r;
   assign bus.any_req  = |bus.req;
endmodule

// File: tb/tb_acq_rr_arbiter.sv
// Directed bench for acq_rr_arbiter (N_REQ=4, MAX_HOLD=16); follows ARB_TIMEOUT_EN if defined.
module tb_acq_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   acq_rr_arbiter_if #(.N_REQ(4)) bus ();

   acq_rr_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant vector, busy, and (when granted) the matching grant_id.
   task automatic chk_grant(input string tag, input logic [3:0] exp);
      int id;
      id = 0;
      for (int b = 0; b < 4; b++) if (exp[b]) id = b;
      check({tag, "_grant"}, 32'(bus.grant), 32'(exp));
      check({tag, "_busy"}, 32'(bus.busy), 32'(|exp));
      if (exp != 4'b0000) check({tag, "_id"}, 32'(bus.grant_id), 32'(id));
   endtask

   initial begin
      bus.req = 4'b1111;
      repeat (2) @(negedge clk);
      chk_grant("rst_hold", 4'b0000);
      check("rst_id", 32'(bus.grant_id), 32'd0);
      check("rst_any_req", 32'(bus.any_req), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk_grant("rst_release", 4'b0001);

      // rotation 0,1,2,3,0 with one bubble between grants
      for (int k = 0; k < 5; k++) begin
         int id;
         id = k % 4;
         chk_grant($sformatf("rot%0d_first", k), 4'(1 << id));
         repeat (2) @(negedge clk);
         chk_grant($sformatf("rot%0d_held", k), 4'(1 << id));
         bus.req[id] = 1'b0;
         @(negedge clk);
         chk_grant($sformatf("rot%0d_bubble", k), 4'b0000);
         bus.req[id] = 1'b1;
         @(negedge clk);
      end
      chk_grant("after_rot", 4'b0010);

      // wrap: last grant to 2, then req 0011 -> 0 then 1
      bus.req = 4'b0100;
      @(negedge clk); chk_grant("to2_bubble", 4'b0000);
      @(negedge clk); chk_grant("to2", 4'b0100);
      bus.req = 4'b0011;
      @(negedge clk); chk_grant("wrap_bubble", 4'b0000);
      @(negedge clk); chk_grant("wrap0", 4'b0001);
      bus.req = 4'b0010;
      @(negedge clk); chk_grant("wrap1_bubble", 4'b0000);
      @(negedge clk); chk_grant("wrap1", 4'b0010);

      // new request during grant ignored, then served in rotation order
      bus.req = 4'b1011;
      @(negedge clk); chk_grant("ignore_new", 4'b0010);
      bus.req = 4'b1001;
      @(negedge clk); chk_grant("sim_bubble", 4'b0000);
      @(negedge clk); chk_grant("sim3", 4'b1000);
      bus.req = 4'b0001;
      @(negedge clk); chk_grant("wait0_bubble", 4'b0000);
      @(negedge clk); chk_grant("wait0", 4'b0001);

      // hold: only req[2] for 40 cycles
      bus.req = 4'b0100;
      @(negedge clk); chk_grant("hold_bubble", 4'b0000);
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
`ifdef ARB_TIMEOUT_EN
         chk_grant($sformatf("hold%0d", i), ((i % 17) < 16) ? 4'b0100 : 4'b0000);
`else
         chk_grant($sformatf("hold%0d", i), 4'b0100);
`endif
         @(negedge clk);
      end

      // async reset mid-grant
      bus.req = 4'b0010;
      @(negedge clk); chk_grant("pre_rst_bubble", 4'b0000);
      @(negedge clk); chk_grant("pre_rst", 4'b0010);
      #2 rst = 1'b1;
      #1 chk_grant("async_rst", 4'b0000);
      check("async_rst_id", 32'(bus.grant_id), 32'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk); chk_grant("regrant", 4'b0010);

      bus.req = 4'b1010;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         chk_grant($sformatf("tmo%0d", i), 4'b0010);
         @(negedge clk);
      end
      chk_grant("tmo_bubble", 4'b0000);
      @(negedge clk); chk_grant("tmo_next", 4'b1000);
`else
      for (int i = 0; i < 20; i++) begin
         chk_grant($sformatf("keep%0d", i), 4'b0010);
         @(negedge clk);
      end
`endif

      // ptr returns to N_REQ-1 on reset: 0110 must go to 1, not 2
      #2 rst = 1'b1;
      bus.req = 4'b0110;
      #1 chk_grant("ptr_rst", 4'b0000);
      @(negedge clk) rst = 1'b0;
      @(negedge clk); chk_grant("ptr_restart", 4'b0010);

      bus.req = 4'b0000;
      #1 check("any_req_low", 32'(bus.any_req), 32'd0);
      @(negedge clk); chk_grant("final_idle", 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timed out");
   end
endmodule
